// File: rtl/sorter_scheduler.sv
// -----------------------------------------------------------------------------
// sorter_scheduler
//   Shares one 8-byte descending Sorter among NUM_REQ requesters. A
//   round-robin arbiter grants one request at a time. The winner's 64-bit
//   vector is registered onto sort_in. After SORT_LAT edges, sort_out is
//   captured and returned on resp_* together with the requester's id. The
//   response is held until the consumer accepts it.
//
//   Optional feature: define SORT_SCHED_CHECK_EN to add a checker. It raises
//   a sticky chk_err if a captured sort_out is not in descending byte order.
//   When the macro is undefined, chk_err is tied to 0.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous reset, active low
//   req_valid   per-requester request valid                 [NUM_REQ]
//   req_data    requester k vector at [64k+63:64k]           [NUM_REQ*64]
//   req_ready   one-hot grant (combinational)                [NUM_REQ]
//   sort_in     to Sorter input                              [64]
//   sort_out    from Sorter output                           [64]
//   resp_valid  sorted result available
//   resp_data   sorted vector, byte 0 ([63:56]) is largest   [64]
//   resp_id     owner of resp_data                           [ID_W]
//   resp_ready  consumer accepts the response
//   busy        high whenever the FSM is not idle
//   chk_err     sticky ordering-error flag
// -----------------------------------------------------------------------------
module sorter_scheduler #(
  parameter  int NUM_REQ  = 4,
  parameter  int SORT_LAT = 1,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*64-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [63:0]            sort_in,
  input  logic [63:0]            sort_out,
  output logic                   resp_valid,
  output logic [63:0]            resp_data,
  output logic [ID_W-1:0]        resp_id,
  input  logic                   resp_ready,
  output logic                   busy,
  output logic                   chk_err
);

  localparam int CNT_W = (SORT_LAT > 0) ? $clog2(SORT_LAT + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  id_q;
  logic [CNT_W-1:0] cnt;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W:0]    idx;

  // Rotating priority scan: the first valid requester starting at rr_ptr wins.
  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!win_found && req_valid[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  // Gated with rst_n so no grant is offered while reset is asserted.
  assign req_ready = (rst_n && state == IDLE && win_found)
                   ? (NUM_REQ'(1) << win_id) : '0;
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      cnt        <= '0;
      sort_in    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A grant always results in a transfer, because req_ready is
          // raised only for a valid requester.
          if (win_found) begin
            sort_in <= req_data[win_id*64 +: 64];
            id_q    <= win_id;
            rr_ptr  <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
            cnt     <= CNT_W'(SORT_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_data  <= sort_out;
            resp_id    <= id_q;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SORT_SCHED_CHECK_EN
  function automatic logic is_desc(input logic [63:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 7; i++)
      if (v[63-8*i -: 8] < v[55-8*i -: 8]) ok = 1'b0;
    return ok;
  endfunction

  // The check runs on the same edge that captures sort_out into resp_data.
  always_ff @(posedge clk) begin
    if (!rst_n)
      chk_err <= 1'b0;
    else if (state == WAIT && cnt == '0 && !is_desc(sort_out))
      chk_err <= 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorter_scheduler.sv
module tb_sorter_scheduler;

  localparam int NUM_REQ = 4;
`ifdef SORT_SCHED_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*64-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [63:0]           sort_in;
  logic [63:0]           sort_out;
  logic                  resp_valid;
  logic [63:0]           resp_data;
  logic [1:0]            resp_id;
  logic                  resp_ready;
  logic                  busy;
  logic                  chk_err;

  logic                  stub_mode;
  int                    n_cmp = 0;
  int                    n_err = 0;

  sorter_scheduler #(.NUM_REQ(NUM_REQ), .SORT_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .sort_in    (sort_in),
    .sort_out   (sort_out),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .busy       (busy),
    .chk_err    (chk_err)
  );

  always #5 clk = ~clk;

  // Reference sort: descending, byte 0 at [63:56].
  function automatic logic [63:0] sort_desc(input logic [63:0] v);
    logic [7:0]  b [8];
    logic [7:0]  t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) b[i] = v[63-8*i -: 8];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7; j++)
        if (b[j] < b[j+1]) begin t = b[j]; b[j] = b[j+1]; b[j+1] = t; end
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = b[i];
    return r;
  endfunction

  // Sorter model with a single input register.
  always @(posedge clk)
    sort_out <= stub_mode ? 64'h0000000000000102 : sort_desc(sort_in);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input string name);
    int c;
    c = 0;
    while (!resp_valid && c < 8) begin step(); c++; end
    n_cmp++;
    if (resp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_timeout: resp_valid=%b after %0d cycles, need 1", name, resp_valid, c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; resp_ready = 1'b0; stub_mode = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) req_data[k*64 +: 64] = 64'h1111111111111111 * (k + 1);
    repeat (3) step();
    n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL rst_req_ready: got %h need 0", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b need 0", resp_valid); end
    n_cmp++; if (resp_data !== 64'h0) begin n_err++; $display("FAIL rst_resp_data: got %h need 0", resp_data); end
    n_cmp++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL rst_resp_id: got %0d need 0", resp_id); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b need 0", busy); end
    n_cmp++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL rst_chk_err: got %b need 0", chk_err); end
    n_cmp++; if (sort_in !== 64'h0) begin n_err++; $display("FAIL rst_sort_in: got %h need 0", sort_in); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_first_grant: got %b need 0001", req_ready); end
    req_valid = 4'h0;
    step();
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_data[2*64 +: 64] = 64'h0102030405060708;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b need 0100", req_ready); end
    step();
    req_valid = 4'h0;
    resp_ready = 1'b1;  // high while resp_valid=0 must not matter
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b need 1", busy); end
    n_cmp++; if (sort_in !== 64'h0102030405060708) begin n_err++; $display("FAIL single_sort_in: got %h need 0102030405060708", sort_in); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL single_early0: got %b need 0", resp_valid); end
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL single_early1: got %b need 0", resp_valid); end
    n_cmp++; if (sort_in !== 64'h0102030405060708) begin n_err++; $display("FAIL single_sort_in_hold: got %h", sort_in); end
    step();
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL single_resp_valid: got %b need 1", resp_valid); end
    n_cmp++; if (resp_data !== 64'h0807060504030201) begin n_err++; $display("FAIL single_resp_data: got %h need 0807060504030201", resp_data); end
    n_cmp++; if (resp_id !== 2'd2) begin n_err++; $display("FAIL single_resp_id: got %0d need 2", resp_id); end
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL single_accept: got %b need 0", resp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b need 0", busy); end
    resp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_k [5] = '{0, 1, 2, 3, 0};
    logic [63:0] d;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req_data[0*64 +: 64] = 64'h10F0203040506070;
    req_data[1*64 +: 64] = 64'hA1B2C3D4E5F60718;
    req_data[2*64 +: 64] = 64'h0000FFFF0000FFFF;
    req_data[3*64 +: 64] = 64'h5A5A5A5A01020304;
    req_valid = 4'hF;
    resp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      d = req_data[exp_k[n]*64 +: 64];
      n_cmp++; if (req_ready !== (4'b0001 << exp_k[n])) begin n_err++; $display("FAIL rr_grant%0d: got %b need k=%0d", n, req_ready, exp_k[n]); end
      step();
      n_cmp++; if (sort_in !== d) begin n_err++; $display("FAIL rr_sort_in%0d: got %h need %h", n, sort_in, d); end
      wait_resp("rr");
      n_cmp++; if (resp_id !== 2'(exp_k[n])) begin n_err++; $display("FAIL rr_id%0d: got %0d need %0d", n, resp_id, exp_k[n]); end
      n_cmp++; if (resp_data !== sort_desc(d)) begin n_err++; $display("FAIL rr_data%0d: got %h need %h", n, resp_data, sort_desc(d)); end
      step();
    end
    req_valid = 4'h0;
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    d = 64'h3377115599002244;
    req_data[1*64 +: 64] = d;
    req_data[3*64 +: 64] = 64'h0123456789ABCDEF;
    req_valid = 4'b1010;  // rr_ptr=1, so k=1 wins and k=3 waits
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant: got %b need 0010", req_ready); end
    step();
    req_valid = 4'b1000;
    wait_resp("bp");
    for (int c = 0; c < 10; c++) begin
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid c%0d: got %b need 1", c, resp_valid); end
      n_cmp++; if (resp_data !== 64'h9977554433221100) begin n_err++; $display("FAIL bp_data c%0d: got %h need 9977554433221100", c, resp_data); end
      n_cmp++; if (resp_id !== 2'd1) begin n_err++; $display("FAIL bp_id c%0d: got %0d need 1", c, resp_id); end
      n_cmp++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL bp_req_ready c%0d: got %b need 0", c, req_ready); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy c%0d: got %b need 1", c, busy); end
      step();
    end
    resp_ready = 1'b1;
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_accept: got %b need 0", resp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b need 0", busy); end
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_next_grant: got %b need 1000", req_ready); end
    resp_ready = 1'b0;
    req_valid = 4'h0;
  endtask

  task automatic test_reset_midflight();
    req_data[1*64 +: 64] = 64'hDEADBEEF00112233;
    req_valid = 4'b0010;  // rr_ptr=2: scan wraps to k=1
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_grant: got %b need 0010", req_ready); end
    step();
    req_valid = 4'h0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b need 0", busy); end
    n_cmp++; if (sort_in !== 64'h0) begin n_err++; $display("FAIL mid_sort_in: got %h need 0", sort_in); end
    resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_resp c%0d: got %b need 0", c, resp_valid); end
      step();
    end
    resp_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_rr_ptr: got %b need 0001", req_ready); end
    req_valid = 4'h0;
    step();
  endtask

  task automatic test_checker();
    stub_mode = 1'b1;
    req_data[0*64 +: 64] = 64'h0807060504030201;
    req_valid = 4'b0001;
    step();
    req_valid = 4'h0;
    wait_resp("chk");
    n_cmp++; if (resp_data !== 64'h0000000000000102) begin n_err++; $display("FAIL chk_data: got %h need 0000000000000102", resp_data); end
    n_cmp++; if (resp_id !== 2'd0) begin n_err++; $display("FAIL chk_id: got %0d need 0", resp_id); end
    n_cmp++; if (chk_err !== EXP_CHK) begin n_err++; $display("FAIL chk_set: got %b need %b", chk_err, EXP_CHK); end
    resp_ready = 1'b1;
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL chk_accept: got %b need 0", resp_valid); end
    resp_ready = 1'b0;
    stub_mode = 1'b0;
    req_data[1*64 +: 64] = 64'h0102030405060708;
    req_valid = 4'b0010;
    step();
    req_valid = 4'h0;
    wait_resp("chk2");
    n_cmp++; if (resp_data !== 64'h0807060504030201) begin n_err++; $display("FAIL chk2_data: got %h need 0807060504030201", resp_data); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    repeat (2) step();
    n_cmp++; if (chk_err !== EXP_CHK) begin n_err++; $display("FAIL chk_sticky: got %b need %b", chk_err, EXP_CHK); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (chk_err !== 1'b0) begin n_err++; $display("FAIL chk_clear: got %b need 0", chk_err); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b0; stub_mode = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_checker();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
